dm_responder: RTL and testbench

- Synthesizable data-memory responder on the processor's data-memory interface. It serves the dm_rd and dm_wr requests issued by pipelinedPS.
- Replaces the behavioural DM model in the bench, using the same edge timing.
- Adds a host side that preloads memory, launches the processor with a one-cycle start pulse and waits for stop.
- After the run, the host side reads back results and reports run cycles and timeout.

---
 rtl/dm_responder.sv | 178 +++++++++++++++++
 tb/tb_dm_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: data-memory responder for the pipelined processor plus a
// host port that preloads memory, launches a run and reads results back.
// Processor reads are sampled on the falling edge so data is ready before
// the next rising edge; all writes and the run-control FSM use the rising edge.
module dm_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter int TIMEOUT    = 500000,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  start,
  input  logic                  stop,
  input  logic                  host_go,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  TERM_CNT = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
  logic [DATA_WIDTH-1:0] dm_r_data_q, dm_r_data_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;

  logic                  dm_in_range, host_in_range;
  logic [IDX_W-1:0]      dm_idx, host_idx;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  // Address decode: out-of-range addresses read as zero and never write.
  always_comb begin
    dm_in_range   = ({1'b0, dm_addr} < DEPTH_L);
    host_in_range = ({1'b0, host_addr} < DEPTH_L);
    dm_idx        = dm_addr[IDX_W-1:0];
    host_idx      = host_addr[IDX_W-1:0];
  end

  // Single write port: processor owns it in RUN, host owns it in IDLE/DONE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    case (state_q)
      S_RUN: begin
        if (dm_wr && dm_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = dm_idx;
          mem_wdata = dm_w_data;
        end
      end
      S_IDLE, S_DONE: begin
        if (host_we && host_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = host_idx;
          mem_wdata = host_wdata;
        end
      end
      default: ;
    endcase
  end

  // Memory array write on the rising edge.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset so contents survive rst and map onto plain RAM.
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read-data next values: processor read holds when dm_rd is low.
  always_comb begin
    dm_r_data_d = dm_r_data_q;
    if (dm_rd) begin
      dm_r_data_d = dm_in_range ? mem[dm_idx] : '0;
    end
    host_rdata_d = host_in_range ? mem[host_idx] : '0;
  end

  // Processor read port samples on the falling edge, ahead of the next write edge.
  always_ff @(negedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      dm_r_data_q <= '0;
    end else begin
      dm_r_data_q <= dm_r_data_d;
    end
  end

  // Run-control FSM next state; cycle_count counts RUN cycles that did not exit.
  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    cnt_inc       = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_ONE;
    case (state_q)
      S_IDLE: begin
        if (host_go) state_d = S_START;
      end
      S_START: begin
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        state_d       = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else if (cycle_count_q == TERM_CNT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          cycle_count_d = cnt_inc;
        end
      end
      S_DONE: begin
        if (host_go) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
  end

  // Run-control registers and host read port on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign dm_r_data   = dm_r_data_q;
  assign host_rdata  = host_rdata_q;
  assign start       = start_q;
  assign busy        = (state_q == S_START) || (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed testbench for dm_responder: one instance with a long timeout and a
// 9-bit address (so out-of-range addresses exist) and one with TIMEOUT=16.
module tb_dm_responder;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance signals
  logic [AW-1:0] dm_addr = '0;
  logic          dm_rd = 1'b0, dm_wr = 1'b0;
  logic [DW-1:0] dm_w_data = '0;
  logic [DW-1:0] dm_r_data;
  logic          start;
  logic          stop = 1'b0;
  logic          host_go = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [DW-1:0] host_rdata;
  logic          busy, done, timeout;
  logic [31:0]   cycle_count;

  // Timeout instance signals
  logic [7:0]    to_dm_addr = '0;
  logic          to_dm_rd = 1'b0, to_dm_wr = 1'b0;
  logic [DW-1:0] to_dm_w_data = '0;
  logic [DW-1:0] to_dm_r_data;
  logic          to_start;
  logic          to_stop = 1'b0;
  logic          to_host_go = 1'b0, to_host_we = 1'b0;
  logic [7:0]    to_host_addr = '0;
  logic [DW-1:0] to_host_wdata = '0;
  logic [DW-1:0] to_host_rdata;
  logic          to_busy, to_done, to_timeout;
  logic [31:0]   to_cycle_count;

  int checks = 0;
  int errors = 0;

  dm_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256), .TIMEOUT(1000), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_w_data(dm_w_data),
    .dm_r_data(dm_r_data), .start(start), .stop(stop),
    .host_go(host_go), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  dm_responder #(
    .ADDR_WIDTH(8), .DATA_WIDTH(DW), .DEPTH(256), .TIMEOUT(16), .CNT_WIDTH(32)
  ) dut_to (
    .clk(clk), .rst(rst),
    .dm_addr(to_dm_addr), .dm_rd(to_dm_rd), .dm_wr(to_dm_wr), .dm_w_data(to_dm_w_data),
    .dm_r_data(to_dm_r_data), .start(to_start), .stop(to_stop),
    .host_go(to_host_go), .host_we(to_host_we), .host_addr(to_host_addr),
    .host_wdata(to_host_wdata), .host_rdata(to_host_rdata),
    .busy(to_busy), .done(to_done), .timeout(to_timeout), .cycle_count(to_cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_we    = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    host_addr = a;
    tick();
    check(tag, 32'(host_rdata), 32'(exp));
  endtask

  initial begin
    int runs;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_count", cycle_count, 32'd0);
    check("rst_dm_rdata", 32'(dm_r_data), 32'd0);
    check("rst_host_rdata", 32'(host_rdata), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Preload and read back, including an out-of-range address
    host_write(9'd0, 16'h0003);
    host_write(9'd1, 16'h0004);
    host_write(9'd5, 16'h0055);
    host_write(9'd10, 16'h0000);
    host_write(9'd300, 16'hBEEF);
    host_read("host_rd_1", 9'd1, 16'h0004);
    host_read("host_rd_300", 9'd300, 16'h0000);

    // Processor write in IDLE is ignored
    dm_wr = 1'b1; dm_addr = 9'd5; dm_w_data = 16'h0099;
    tick();
    dm_wr = 1'b0;
    host_read("idle_dm_wr_blocked", 9'd5, 16'h0055);

    // Processor reads work in any state; out-of-range reads return zero
    dm_rd = 1'b1; dm_addr = 9'd1;
    half();
    check("dm_rd_1", 32'(dm_r_data), 32'h0004);
    dm_addr = 9'd300;
    half();
    check("dm_rd_300", 32'(dm_r_data), 32'h0000);
    dm_rd = 1'b0;
    tick();

    // Normal run
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    check("start_in_start", 32'(start), 32'd1);
    check("busy_in_start", 32'(busy), 32'd1);
    tick();
    check("start_one_cycle", 32'(start), 32'd0);
    check("busy_in_run", 32'(busy), 32'd1);
    for (int k = 1; k <= 41; k++) begin
      dm_wr = 1'b0; dm_rd = 1'b0; host_we = 1'b0; host_go = 1'b0; stop = 1'b0;
      case (k)
        1: begin
          dm_wr = 1'b1; dm_addr = 9'd10; dm_w_data = 16'h0007;
          host_we = 1'b1; host_addr = 9'd5; host_wdata = 16'h00AA;
        end
        2: begin
          dm_rd = 1'b1; dm_wr = 1'b1; dm_addr = 9'd0; dm_w_data = 16'h00FF;
          half();
          check("same_cycle_old_data", 32'(dm_r_data), 32'h0003);
        end
        3: begin
          dm_rd = 1'b1; dm_addr = 9'd0;
          half();
          check("read_after_write", 32'(dm_r_data), 32'h00FF);
        end
        4: begin
          dm_addr = 9'd1;
          half();
          check("dm_rdata_hold", 32'(dm_r_data), 32'h00FF);
        end
        5: host_go = 1'b1;
        10: check("count_mid_run", cycle_count, 32'd9);
        41: stop = 1'b1;
        default: ;
      endcase
      tick();
    end
    dm_wr = 1'b0; dm_rd = 1'b0; host_we = 1'b0; host_go = 1'b0; stop = 1'b0;
    check("run_done", 32'(done), 32'd1);
    check("run_busy", 32'(busy), 32'd0);
    check("run_timeout", 32'(timeout), 32'd0);
    check("run_count", cycle_count, 32'd40);
    host_read("result_mem10", 9'd10, 16'h0007);
    host_read("run_host_we_blocked", 9'd5, 16'h0055);
    host_read("result_mem0", 9'd0, 16'h00FF);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_in_done_ignored", 32'(done), 32'd1);

    // Timeout run on the TIMEOUT=16 instance
    to_host_go = 1'b1;
    tick();
    to_host_go = 1'b0;
    tick();
    runs = 0;
    for (int n = 1; n <= 100; n++) begin
      tick();
      if (to_done) begin
        runs = n;
        break;
      end
    end
    check("to_run_cycles", 32'(runs), 32'd16);
    check("to_timeout", 32'(to_timeout), 32'd1);
    check("to_count", to_cycle_count, 32'd15);
    to_stop = 1'b1;
    tick();
    tick();
    check("to_stop_ignored_done", 32'(to_done), 32'd1);
    check("to_stop_ignored_count", to_cycle_count, 32'd15);
    check("to_stop_ignored_timeout", 32'(to_timeout), 32'd1);

    // Relaunch from DONE with stop already high: exits after one RUN cycle
    to_host_go = 1'b1;
    tick();
    to_host_go = 1'b0;
    check("relaunch_start", 32'(to_start), 32'd1);
    tick();
    tick();
    check("relaunch_done", 32'(to_done), 32'd1);
    check("relaunch_timeout_clear", 32'(to_timeout), 32'd0);
    check("relaunch_count", to_cycle_count, 32'd0);

    // stop on the terminal count wins over timeout
    to_stop = 1'b0;
    to_host_go = 1'b1;
    tick();
    to_host_go = 1'b0;
    tick();
    repeat (15) tick();
    check("term_not_done_yet", 32'(to_done), 32'd0);
    to_stop = 1'b1;
    tick();
    to_stop = 1'b0;
    check("term_done", 32'(to_done), 32'd1);
    check("term_timeout", 32'(to_timeout), 32'd0);
    check("term_count", to_cycle_count, 32'd15);

    // Reset mid-RUN aborts to IDLE; memory contents persist
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    tick();
    tick();
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_count", cycle_count, 32'd0);
    check("midrst_dm_rdata", 32'(dm_r_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("after_rst_idle_busy", 32'(busy), 32'd0);
    check("after_rst_idle_done", 32'(done), 32'd0);
    host_read("after_rst_mem10", 9'd10, 16'h0007);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
